// File: rtl/mseq_ber_checker.sv
// mseq_ber_checker: self-synchronising m-sequence checker with lock control,
// windowed and cumulative bit-error counting.
module mseq_ber_checker #(
    parameter int                     LFSR_DEGREE   = 7,
    parameter logic [LFSR_DEGREE-1:0] LFSR_TAPS     = 7'b1100000,
    parameter int                     LOCK_COUNT    = 16,
    parameter int                     WINDOW_LOG2   = 10,
    parameter int                     UNLOCK_ERRORS = 8,
    parameter int                     CNT_W         = 32
) (
    input  logic                   receiver_clk,
    input  logic                   receiver_rst,
    input  logic                   data_i,
    input  logic                   data_valid_i,
    input  logic                   clear_i,
    output logic                   locked_o,
    output logic [1:0]             state_o,
    output logic [CNT_W-1:0]       total_bits_o,
    output logic [CNT_W-1:0]       total_errors_o,
    output logic [WINDOW_LOG2:0]   window_errors_o,
    output logic                   window_done_o,
    output logic                   sync_loss_o
);
    typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    state_t                 r_state;
    logic [LFSR_DEGREE-1:0] r_s;
    logic [5:0]             r_fill;
    logic [7:0]             r_match;
    logic [WINDOW_LOG2-1:0] r_wcnt;
    logic [WINDOW_LOG2:0]   r_acc;
    logic [LFSR_DEGREE-1:0] w_s_next;
    logic [WINDOW_LOG2:0]   w_acc_next;
    logic                   w_p, w_err, w_b;

    assign w_p        = ^(r_s & LFSR_TAPS);
    assign w_err      = data_i ^ w_p;
    // In VERIFY a match means data_i == p, so shifting data_i covers both branches.
    assign w_b        = (r_state == LOCKED) ? w_p : data_i;
    assign w_s_next   = {r_s[LFSR_DEGREE-2:0], w_b};
    assign w_acc_next = r_acc + (WINDOW_LOG2+1)'(w_err);
    assign state_o    = r_state;

    always_ff @(posedge receiver_clk or posedge receiver_rst) begin
        if (receiver_rst) begin
            r_state         <= SEARCH;
            r_s             <= '0;
            r_fill          <= '0;
            r_match         <= '0;
            r_wcnt          <= '0;
            r_acc           <= '0;
            locked_o        <= 1'b0;
            total_bits_o    <= '0;
            total_errors_o  <= '0;
            window_errors_o <= '0;
            window_done_o   <= 1'b0;
            sync_loss_o     <= 1'b0;
        end else begin
            window_done_o <= 1'b0;
            sync_loss_o   <= 1'b0;
            if (data_valid_i) begin
                r_s <= w_s_next;
                case (r_state)
                    SEARCH: begin
                        r_fill <= r_fill + 6'd1;
                        if (r_fill + 6'd1 == 6'(LFSR_DEGREE)) begin
                            r_fill  <= '0;
                            r_match <= '0;
                            if (|w_s_next) r_state <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (!w_err) begin
                            r_match <= r_match + 8'd1;
                            if (r_match + 8'd1 == 8'(LOCK_COUNT)) begin
                                r_state  <= LOCKED;
                                locked_o <= 1'b1;
                            end
                        end else begin
                            r_match <= '0;
                            r_fill  <= 6'd1;
                            r_state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        if (~&total_bits_o) total_bits_o <= total_bits_o + CNT_W'(1);
                        if (w_err && ~&total_errors_o) total_errors_o <= total_errors_o + CNT_W'(1);
                        r_wcnt <= r_wcnt + WINDOW_LOG2'(1);
                        r_acc  <= w_acc_next;
                        // Counter wraps to zero at the window end, so leaving LOCKED here leaves it cleared.
                        if (&r_wcnt) begin
                            window_errors_o <= w_acc_next;
                            window_done_o   <= 1'b1;
                            r_acc           <= '0;
                            if (int'(w_acc_next) >= UNLOCK_ERRORS) begin
                                r_state     <= SEARCH;
                                locked_o    <= 1'b0;
                                sync_loss_o <= 1'b1;
                                r_fill      <= '0;
                            end
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
            if (clear_i) begin
                total_bits_o    <= '0;
                total_errors_o  <= '0;
                window_errors_o <= '0;
                r_wcnt          <= '0;
                r_acc           <= '0;
            end
        end
    end
endmodule

// File: doc/mseq_ber_checker.md
# mseq_ber_checker

Parametrised m-sequence receiver-side checker: self-synchronises a local LFSR to the demodulated bit stream, declares lock, then counts bit errors per fixed window and cumulatively. Sits after the receiver's demodulator/decision stage, on the receiver clock domain. Generalises the fixed PRBS link check to any LFSR degree and polynomial, with lock/loss-of-lock control and windowed BER reporting.

## Interface
- LFSR_DEGREE, 7, LFSR length n (3..31)
- LFSR_TAPS, 7'b1100000, feedback mask (bit k = tap on stage k+1); default x^7+x^6+1
- LOCK_COUNT, 16, consecutive correct predictions needed to lock (1..255)
- WINDOW_LOG2, 10, BER window = 2^WINDOW_LOG2 valid bits
- UNLOCK_ERRORS, 8, window errors at/above which lock is dropped
- CNT_W, 32, width of cumulative counters
- receiver_clk  in  1  single clock, rising edge
- receiver_rst  in  1  asynchronous, active-high reset
- data_i  in  1  received hard-decision bit
- data_valid_i  in  1  data_i is sampled only when high
- clear_i  in  1  synchronous clear of cumulative and window counters (lock state kept)
- locked_o  out  1  high in LOCKED
- state_o  out  2  0=SEARCH, 1=VERIFY, 2=LOCKED
- total_bits_o  out  CNT_W  valid bits checked while LOCKED, saturating
- total_errors_o  out  CNT_W  errors while LOCKED, saturating
- window_errors_o  out  WINDOW_LOG2+1  error count of last completed window
- window_done_o  out  1  one-cycle pulse, window_errors_o updated
- sync_loss_o  out  1  one-cycle pulse on LOCKED->SEARCH

## Operation
- LFSR state s[n-1:0], Fibonacci form; prediction p = XOR-reduce(s & LFSR_TAPS); shift s <= {s[n-2:0], b}.
- All state advances only on data_valid_i=1; otherwise everything holds (pulses deassert).
- SEARCH: shift b=data_i; fill counter increments; after n valid bits -> VERIFY if s (post-shift) nonzero, else restart fill (all-zero lockup never verified).
- VERIFY: if data_i==p shift b=p, match counter++; at LOCK_COUNT matches -> LOCKED. Mismatch: shift b=data_i, match counter cleared, fill counter set to 1, -> SEARCH.
- LOCKED: LFSR free-runs (b=p), never reloaded from input. err = data_i^p. total_bits++, total_errors += err (both saturate at all-ones). Window bit counter and window error accumulator advance.
- Window end (2^WINDOW_LOG2-th locked valid bit, counted inclusive): window_errors_o <= acc+err, window_done_o pulses, acc cleared. If acc+err >= UNLOCK_ERRORS: -> SEARCH, sync_loss_o pulses, fill counter 0.
- Leaving LOCKED clears window counter/accumulator; window_errors_o keeps last value.
- clear_i: zero total_bits_o, total_errors_o, window counter, accumulator, window_errors_o; state/LFSR unaffected; wins over a simultaneous increment.
- window_errors_o width holds 2^WINDOW_LOG2 without overflow.

## Timing
- All outputs registered; reset values: state SEARCH, s=0, locked_o=0, state_o=0, all counters 0, window_errors_o=0, window_done_o=0, sync_loss_o=0.
- Reset asserted mid-operation returns to reset values immediately (async), resumes SEARCH on first edge after release.
- Latency: locked_o rises on the edge that samples the (n+LOCK_COUNT)-th valid bit of a clean stream; state_o/counters update on the same edge as the sampling valid bit.
- window_done_o and sync_loss_o asserted for exactly one cycle, same edge as window_errors_o update; both may pulse together.
- Back-to-back valid every cycle supported; no throughput limit.

## Test plan
- Clean PRBS7 (x^7+x^6+1, seed 7'h7F), valid every cycle -> state_o 0→1 after 7 bits, locked_o=1 after bit 23; after 1024 more bits window_done_o pulses, window_errors_o=0, total_bits_o=1024.
- Locked, flip 3 bits in one window -> window_errors_o=3, total_errors_o=3, locked_o stays 1; next clean window reports 0.
- Locked, flip 8 bits in one window -> at window end window_errors_o=8, window_done_o and sync_loss_o pulse together, locked_o=0; relock 23 valid bits later.
- All-zero input stream -> state_o stays 0 forever, locked_o=0.
- Bit flipped during VERIFY (bit 15) -> back to SEARCH, lock at bit 15+6+16 counts as required; data_valid_i toggled 50% -> identical lock bit index.
- clear_i pulse mid-window, and receiver_rst pulse while LOCKED -> counters 0 / all outputs at reset values; with CNT_W=4, 20 errors -> total_errors_o saturates at 15.
